// File: rtl/video_types.sv
`default_nettype none
// ============================================================================
// Module      : video_types (package)
// Description : Shared types and constants for the video unit: the LCD mode
//               encoding, scanline/dot timing constants, STAT enable bit
//               positions and the dot/line -> mode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package video_types;

  typedef enum logic [1:0] {
    HBLANK     = 2'd0,
    VBLANK     = 2'd1,
    OAM_SCAN   = 2'd2,
    PIXEL_XFER = 2'd3
  } LcdMode;

  localparam logic [8:0] DOTS_PER_LINE   = 9'd456;
  localparam logic [7:0] LINES_PER_FRAME = 8'd154;
  localparam logic [7:0] VISIBLE_LINES   = 8'd144;
  localparam logic [8:0] OAM_DOTS        = 9'd80;
  localparam logic [8:0] XFER_DOTS       = 9'd172;

  localparam logic [8:0] LAST_DOT  = DOTS_PER_LINE - 9'd1;
  localparam logic [7:0] LAST_LINE = LINES_PER_FRAME - 8'd1;
  localparam logic [8:0] XFER_END  = OAM_DOTS + XFER_DOTS;

  // Bit positions inside stat_irq_en
  localparam int STAT_EN_HBLANK = 0;
  localparam int STAT_EN_VBLANK = 1;
  localparam int STAT_EN_OAM    = 2;
  localparam int STAT_EN_LYC    = 3;

  // Mode implied by a given line/dot position of an enabled display
  function automatic LcdMode decode_mode(input logic [7:0] line, input logic [8:0] dot);
    if (line >= VISIBLE_LINES)
      return VBLANK;
    else if (dot < OAM_DOTS)
      return OAM_SCAN;
    else if (dot < XFER_END)
      return PIXEL_XFER;
    else
      return HBLANK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_stat_irq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_stat_irq
// Description : STAT interrupt generator. Masks the mode/coincidence sources
//               with their enables, ORs them into the STAT line and emits a
//               one-cycle request on each rising edge of that line.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               mode              - current (registered) LCD mode
//               coincidence       - LY == LYC
//               stat_irq_en[3:0]  - source enables (0 HBlank, 1 VBlank,
//                                   2 OAM, 3 LY=LYC)
//               stat_irq          - registered one-cycle request pulse
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_stat_irq
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  LcdMode     mode,
  input  logic       coincidence,
  input  logic [3:0] stat_irq_en,
  output logic       stat_irq
);

  logic stat_line;
  logic stat_line_q;

  always_comb begin
    stat_line = (stat_irq_en[STAT_EN_HBLANK] && (mode == HBLANK))
             || (stat_irq_en[STAT_EN_VBLANK] && (mode == VBLANK))
             || (stat_irq_en[STAT_EN_OAM]    && (mode == OAM_SCAN))
             || (stat_irq_en[STAT_EN_LYC]    && coincidence);
  end

  // Only a 0->1 transition requests; a line held high by a hand-over
  // between sources stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_line_q <= 1'b0;
      stat_irq    <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      stat_irq    <= stat_line & ~stat_line_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_timing.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing
// Description : LCD timing sequencer. Counts dots and scanlines, drives the
//               PPU mode, LY, LY=LYC coincidence, STAT/VBlank interrupt
//               requests, frame_start and the VRAM/OAM CPU-access locks.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               dot_ce          - dot clock enable
//               lcd_enable      - LCDC bit 7
//               lyc[7:0]        - LY compare value
//               stat_irq_en[3:0]- STAT source enables
//               ly, dot_count, mode, coincidence
//               stat_irq, vblank_irq, frame_start (one-cycle pulses)
//               oam_lock, vram_lock
// Config      : LCD_TIMING_LINE153_QUIRK_EN - when defined, ly reads 0 from
//               dot 4 of line 153 while the line counter stays at 153.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_ce,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_irq_en,
  output logic [7:0] ly,
  output logic [8:0] dot_count,
  output logic [1:0] mode,
  output logic       coincidence,
  output logic       stat_irq,
  output logic       vblank_irq,
  output logic       frame_start,
  output logic       oam_lock,
  output logic       vram_lock
);

`ifdef LCD_TIMING_LINE153_QUIRK_EN
  localparam logic [8:0] QUIRK_DOT = 9'd4;
`endif

  // running is clear until the first dot after enable, which lands on
  // line 0 / dot 0 instead of advancing the counters.
  logic       running;
  logic [7:0] line_q;
  LcdMode     mode_q;

  logic [8:0] nxt_dot;
  logic [7:0] nxt_line;
  logic [7:0] nxt_ly;
  LcdMode     nxt_mode;
  logic [3:0] stat_en_gated;

  always_comb begin
    nxt_dot  = 9'd0;
    nxt_line = 8'd0;
    if (running) begin
      if (dot_count == LAST_DOT) begin
        nxt_dot  = 9'd0;
        nxt_line = (line_q == LAST_LINE) ? 8'd0 : line_q + 8'd1;
      end else begin
        nxt_dot  = dot_count + 9'd1;
        nxt_line = line_q;
      end
    end
    nxt_mode = decode_mode(nxt_line, nxt_dot);
`ifdef LCD_TIMING_LINE153_QUIRK_EN
    nxt_ly = ((nxt_line == LAST_LINE) && (nxt_dot >= QUIRK_DOT)) ? 8'd0 : nxt_line;
`else
    nxt_ly = nxt_line;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running     <= 1'b0;
      dot_count   <= 9'd0;
      line_q      <= 8'd0;
      ly          <= 8'd0;
      mode_q      <= HBLANK;
      oam_lock    <= 1'b0;
      vram_lock   <= 1'b0;
      vblank_irq  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vblank_irq  <= 1'b0;
      frame_start <= 1'b0;
      if (!lcd_enable) begin
        // Disabling clears the counters immediately, even without dot_ce
        running   <= 1'b0;
        dot_count <= 9'd0;
        line_q    <= 8'd0;
        ly        <= 8'd0;
        mode_q    <= HBLANK;
        oam_lock  <= 1'b0;
        vram_lock <= 1'b0;
      end else if (dot_ce) begin
        running     <= 1'b1;
        dot_count   <= nxt_dot;
        line_q      <= nxt_line;
        ly          <= nxt_ly;
        mode_q      <= nxt_mode;
        oam_lock    <= (nxt_mode == OAM_SCAN) || (nxt_mode == PIXEL_XFER);
        vram_lock   <= (nxt_mode == PIXEL_XFER);
        frame_start <= (nxt_line == 8'd0) && (nxt_dot == 9'd0);
        vblank_irq  <= (nxt_line == VISIBLE_LINES) && (nxt_dot == 9'd0);
      end
    end
  end

  assign mode        = mode_q;
  assign coincidence = (ly == lyc);

  // A disabled display raises no STAT requests even though coincidence
  // keeps tracking.
  assign stat_en_gated = lcd_enable ? stat_irq_en : 4'b0000;

  lcd_stat_irq u_stat_irq (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode_q),
    .coincidence (coincidence),
    .stat_irq_en (stat_en_gated),
    .stat_irq    (stat_irq)
  );

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing
// Description : Directed self-checking bench for lcd_timing. Inputs change
//               and outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing;

  logic       clk = 1'b0;
  logic       reset;
  logic       dot_ce;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_irq_en;
  logic [7:0] ly;
  logic [8:0] dot_count;
  logic [1:0] mode;
  logic       coincidence;
  logic       stat_irq;
  logic       vblank_irq;
  logic       frame_start;
  logic       oam_lock;
  logic       vram_lock;

  int passed = 0;
  int total  = 0;
  int pos    = 0;  // dots since frame start (line*456 + dot)

`ifdef LCD_TIMING_LINE153_QUIRK_EN
  localparam logic [7:0] LY_153_LATE = 8'd0;
`else
  localparam logic [7:0] LY_153_LATE = 8'd153;
`endif

  lcd_timing dut (
    .clk         (clk),
    .reset       (reset),
    .dot_ce      (dot_ce),
    .lcd_enable  (lcd_enable),
    .lyc         (lyc),
    .stat_irq_en (stat_irq_en),
    .ly          (ly),
    .dot_count   (dot_count),
    .mode        (mode),
    .coincidence (coincidence),
    .stat_irq    (stat_irq),
    .vblank_irq  (vblank_irq),
    .frame_start (frame_start),
    .oam_lock    (oam_lock),
    .vram_lock   (vram_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance with dot_ce high to the given line/dot of the current frame
  task automatic adv(input int line, input int dot);
    int tgt;
    tgt = line * 456 + dot;
    tick(tgt - pos);
    pos = tgt;
  endtask

  initial begin
    reset = 1'b1; dot_ce = 1'b1; lcd_enable = 1'b1; lyc = 8'd0; stat_irq_en = 4'd0;
    tick(3);
    chk("rst_ly", ly, 0);
    chk("rst_dot", dot_count, 0);
    chk("rst_mode", mode, 0);
    chk("rst_coinc", coincidence, 1);
    chk("rst_pulses", {stat_irq, vblank_irq, frame_start}, 0);
    chk("rst_locks", {oam_lock, vram_lock}, 0);

    // First dot after release: line 0 dot 0, mode 2
    reset = 1'b0;
    tick(1); pos = 0;
    chk("fs_pulse", frame_start, 1);
    chk("fs_ly", ly, 0);
    chk("fs_dot", dot_count, 0);
    chk("fs_mode", mode, 2);
    chk("fs_locks", {oam_lock, vram_lock}, 2'b10);
    adv(0, 1);   chk("fs_end", frame_start, 0);

    // Line 0 walk
    adv(0, 79);  chk("l0d79_mode", mode, 2);
    adv(0, 80);  chk("l0d80_mode", mode, 3);
                 chk("l0d80_locks", {oam_lock, vram_lock}, 2'b11);
    adv(0, 251); chk("l0d251_mode", mode, 3);
    adv(0, 252); chk("l0d252_mode", mode, 0);
                 chk("l0d252_locks", {oam_lock, vram_lock}, 2'b00);
    adv(0, 455); chk("l0d455_ly", ly, 0);
    adv(1, 0);   chk("l1d0_ly", ly, 1);
                 chk("l1d0_mode", mode, 2);

    // HBlank + LYC sources with STAT blocking across line 4 -> 5
    stat_irq_en = 4'b1001; lyc = 8'd5;
    adv(1, 252); chk("hb1_early", stat_irq, 0);
    adv(1, 253); chk("hb1_pulse", stat_irq, 1);
    adv(1, 254); chk("hb1_end", stat_irq, 0);
    adv(4, 253); chk("hb4_pulse", stat_irq, 1);
    adv(5, 0);   chk("l5_coinc", coincidence, 1);
                 chk("l5d0_irq", stat_irq, 0);
    adv(5, 1);   chk("l5_blocked", stat_irq, 0);
    adv(5, 253); chk("hb5_blocked", stat_irq, 0);
    adv(6, 253); chk("hb6_pulse", stat_irq, 1);

    // LYC-only source, lyc = 10
    adv(6, 300); stat_irq_en = 4'b1000; lyc = 8'd10;
    adv(9, 455); chk("l9_coinc", coincidence, 0);
    adv(10, 0);  chk("l10_coinc", coincidence, 1);
                 chk("l10d0_irq", stat_irq, 0);
    adv(10, 1);  chk("l10d1_irq", stat_irq, 1);
    adv(10, 2);  chk("l10d2_irq", stat_irq, 0);
    adv(10, 455); chk("l10d455_coinc", coincidence, 1);
    adv(11, 0);  chk("l11_coinc", coincidence, 0);

    // LYC rewritten mid-line to match the current line
    adv(11, 100); lyc = 8'd11; #1;
    chk("lyc_wr_coinc", coincidence, 1);
    adv(11, 101); chk("lyc_wr_irq", stat_irq, 1);
    lyc = 8'd200; stat_irq_en = 4'd0;

    // VBlank and frame wrap
    adv(143, 455); chk("l143_mode", mode, 0);
                   chk("l143_vbl", vblank_irq, 0);
    adv(144, 0);   chk("l144_ly", ly, 144);
                   chk("l144_mode", mode, 1);
                   chk("l144_vbl", vblank_irq, 1);
                   chk("l144_locks", {oam_lock, vram_lock}, 2'b00);
    adv(144, 1);   chk("l144d1_vbl", vblank_irq, 0);
    adv(153, 3);   chk("l153d3_ly", ly, 153);
                   chk("l153_mode", mode, 1);
    adv(153, 4);   chk("l153d4_ly", ly, LY_153_LATE);
    adv(153, 455); chk("l153d455_ly", ly, LY_153_LATE);
    adv(154, 0);   pos = 0;
                   chk("wrap_ly", ly, 0);
                   chk("wrap_mode", mode, 2);
                   chk("wrap_fs", frame_start, 1);
                   chk("wrap_vbl", vblank_irq, 0);

    // dot_ce low freezes, then disable mid-line without dot_ce
    adv(2, 300);
    dot_ce = 1'b0;
    tick(3);     chk("freeze_dot", dot_count, 300);
                 chk("freeze_ly", ly, 2);
    lcd_enable = 1'b0; stat_irq_en = 4'b0111; lyc = 8'd0;
    tick(1);     chk("dis_ly", ly, 0);
                 chk("dis_dot", dot_count, 0);
                 chk("dis_mode", mode, 0);
                 chk("dis_locks", {oam_lock, vram_lock}, 2'b00);
                 chk("dis_coinc", coincidence, 1);
                 chk("dis_irq", stat_irq, 0);
    dot_ce = 1'b1;
    tick(3);     chk("dis_hold_dot", dot_count, 0);
                 chk("dis_hold_pulses", {stat_irq, vblank_irq, frame_start}, 0);
    lyc = 8'd3; #1;
    chk("dis_coinc_lyc3", coincidence, 0);

    // Re-enable: restart at line 0 mode 2; pulses are one clk even with dot_ce low
    stat_irq_en = 4'b0100;
    lcd_enable = 1'b1;
    tick(1);     chk("re_fs", frame_start, 1);
                 chk("re_mode", mode, 2);
                 chk("re_dot", dot_count, 0);
                 chk("re_irq_early", stat_irq, 0);
    dot_ce = 1'b0;
    tick(1);     chk("re_fs_end", frame_start, 0);
                 chk("re_oam_irq", stat_irq, 1);
                 chk("re_frozen_dot", dot_count, 0);
    tick(1);     chk("re_oam_irq_end", stat_irq, 0);
    dot_ce = 1'b1; pos = 0;
    adv(1, 10);  chk("re_l1_ly", ly, 1);
                 chk("re_l1_dot", dot_count, 10);

    // Reset mid-frame
    reset = 1'b1;
    tick(1);     chk("mid_rst_ly", ly, 0);
                 chk("mid_rst_dot", dot_count, 0);
                 chk("mid_rst_mode", mode, 0);
                 chk("mid_rst_locks", {oam_lock, vram_lock}, 2'b00);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
